// File: rtl/tx_word_gen.sv
// Transmit word source for a serial link output: idle/PRBS7/user/ramp sources,
// a fixed-length training burst, bit-granular rotation and single-word error injection.
module tx_word_gen #(
   parameter int          COUNTER_WIDTH = 32,
   parameter logic [7:0]  TRAIN_WORD    = 8'hB5
) (
   input  logic                     clk160,
   input  logic                     rstb,
   input  logic [1:0]               mode,
   input  logic [7:0]               idle_word,
   input  logic [7:0]               tx_data,
   input  logic                     tx_valid,
   output logic                     tx_ready,
   input  logic [2:0]               bit_shift,
   input  logic                     inject_error,
   input  logic                     train_start,
   input  logic [15:0]              train_len,
   output logic                     training_active,
   input  logic                     reset_counters,
   output logic [7:0]               D_OUT,
   output logic [COUNTER_WIDTH-1:0] word_counter,
   output logic [COUNTER_WIDTH-1:0] underflow_counter
);

   typedef enum logic {RUN = 1'b0, TRAIN = 1'b1} state_t;

   state_t      state;
   logic [15:0] train_cnt;
   logic [7:0]  s1;
   logic [7:0]  prev;
   logic [7:0]  ramp;
   logic [6:0]  lfsr;
   logic [6:0]  lfsr_next;
   logic [7:0]  prbs_word;
   logic [7:0]  src;
   logic [15:0] window;
   logic        run;
   logic        underflow;

   assign run       = (state == RUN);
   assign underflow = run && (mode == 2'd2) && !tx_valid;
   assign tx_ready  = run && (mode == 2'd2);
   assign window    = {prev, s1} >> bit_shift;

   // Eight LFSR steps per word; the first generated bit lands in bit 7.
   always_comb begin
      logic nb;
      nb        = 1'b0;
      lfsr_next = lfsr;
      prbs_word = 8'h00;
      for (int i = 0; i < 8; i++) begin
         nb             = lfsr_next[6] ^ lfsr_next[5];
         prbs_word[7-i] = nb;
         lfsr_next      = {lfsr_next[5:0], nb};
      end
   end

   always_comb begin
      src = idle_word;
      if (!run) begin
         src = TRAIN_WORD;
      end else begin
         case (mode)
            2'd0:    src = idle_word;
            2'd1:    src = prbs_word;
            2'd2:    src = tx_valid ? tx_data : idle_word;
            2'd3:    src = ramp;
            default: src = idle_word;
         endcase
      end
   end

   // Burst controller; training_active is the registered image of state.
   always_ff @(posedge clk160 or negedge rstb) begin
      if (!rstb) begin
         state           <= RUN;
         train_cnt       <= 16'd0;
         training_active <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (train_start && (train_len != 16'd0)) begin
                  state           <= TRAIN;
                  train_cnt       <= train_len;
                  training_active <= 1'b1;
               end
            end
            TRAIN: begin
               train_cnt <= train_cnt - 16'd1;
               if (train_cnt == 16'd1) begin
                  state           <= RUN;
                  training_active <= 1'b0;
               end
            end
            default: begin
               state           <= RUN;
               training_active <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk160 or negedge rstb) begin
      if (!rstb) begin
         s1    <= 8'h00;
         prev  <= 8'h00;
         D_OUT <= 8'h00;
         lfsr  <= 7'h7F;
         ramp  <= 8'h00;
      end else begin
         s1    <= src ^ {7'b0, inject_error && run};
         prev  <= s1;
         D_OUT <= window[7:0];
         if (run && (mode == 2'd1)) lfsr <= lfsr_next;
         if (run && (mode == 2'd3)) ramp <= ramp + 8'd1;
      end
   end

   // Saturating counters; a clear wins over a same-cycle increment.
   always_ff @(posedge clk160 or negedge rstb) begin
      if (!rstb) begin
         word_counter      <= '0;
         underflow_counter <= '0;
      end else if (reset_counters) begin
         word_counter      <= '0;
         underflow_counter <= '0;
      end else begin
         if (run && (word_counter != '1))
            word_counter <= word_counter + COUNTER_WIDTH'(1);
         if (underflow && (underflow_counter != '1))
            underflow_counter <= underflow_counter + COUNTER_WIDTH'(1);
      end
   end

endmodule

// File: doc/tx_word_gen.md
# tx_word_gen

Single-clock transmit word source for the output side of a serial link. Each clk160 cycle it produces one 8-bit word for the downstream 8:1 output serializer; bit 7 is transmitted first. It supports:
- idle, PRBS7, user-stream and ramp sources;
- a fixed-length training burst;
- bit-granular phase rotation;
- error injection, for exercising the receive-side delay scan and error counters.

## Interface
Parameters:
- COUNTER_WIDTH, 32, width of word_counter and underflow_counter
- TRAIN_WORD, 8'hB5, word emitted during training

Ports:
- clk160  in  1  word clock; all logic on rising edge
- rstb  in  1  asynchronous, active-low reset
- mode  in  2  source select: 0 idle (idle_word), 1 PRBS7, 2 user stream, 3 ramp
- idle_word  in  8  word used in mode 0 and on user-stream underflow
- tx_data  in  8  user word
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  user word accepted on this edge when tx_valid also high
- bit_shift  in  3  output rotation, 0..7 bits of delay
- inject_error  in  1  single-cycle request to flip bit 0 of one word
- train_start  in  1  pulse: begin training burst
- train_len  in  16  number of TRAIN_WORD words per burst
- training_active  out  1  high while in TRAIN
- reset_counters  in  1  synchronous clear of both counters
- D_OUT  out  8  word to serializer
- word_counter  out  COUNTER_WIDTH  words sourced in RUN
- underflow_counter  out  COUNTER_WIDTH  mode-2 cycles with tx_valid low

## Operation
- FSM has two states, RUN and TRAIN; reset state is RUN.
- RUN -> TRAIN on train_start when train_len != 0; the down-counter loads train_len.
- train_start with train_len == 0 is ignored. train_start while in TRAIN is ignored.
- TRAIN sources TRAIN_WORD every cycle and decrements the counter. It returns to RUN after exactly train_len words.
- Source stage S1 is registered and captures one word per cycle:
  - TRAIN: TRAIN_WORD.
  - RUN, mode 0: idle_word.
  - RUN, mode 1: next PRBS7 word.
  - RUN, mode 2 with tx_valid high: tx_data.
  - RUN, mode 2 with tx_valid low: idle_word, and underflow_counter increments.
  - RUN, mode 3: ramp register, which then increments and wraps 8'hFF -> 8'h00.
- tx_ready = (state == RUN) && (mode == 2). It is decoded from registered state and the mode input, and is not gated by tx_valid.
- PRBS7 uses polynomial x^7+x^6+1 with seed 7'h7F at reset.
  - Per bit: new = s[6]^s[5]; s <= {s[5:0], new}.
  - Eight steps are taken per word; the first generated bit goes to bit 7.
  - The LFSR advances only on RUN && mode == 1 cycles and is never reseeded except by reset.
- Ramp advances only on RUN && mode == 3 cycles.
- Error injection: when inject_error is high in RUN, the word captured into S1 that cycle is XORed with 8'h01. The pulse is ignored in TRAIN.
- Rotation:
  - prev holds the previous S1 word.
  - D_OUT <= {prev, S1}[7+bit_shift : bit_shift], registered.
  - bit_shift is sampled every cycle; a change affects the next D_OUT with no flush.
- Counters:
  - word_counter increments on every RUN source cycle.
  - Both counters saturate at all-ones.
  - reset_counters clears both and takes precedence over a simultaneous increment.

## Timing
- Reset values: D_OUT 8'h00, S1 8'h00, prev 8'h00, LFSR 7'h7F, ramp 8'h00, both counters 0, training_active 0, state RUN.
- tx_ready follows mode combinationally, so it may be high during reset.
- Latency with bit_shift = 0: a word captured into S1 at edge k appears on D_OUT after edge k+1.
- A user handshake at edge k therefore reaches D_OUT after edge k+1.
- Training: train_start sampled at edge k gives training_active high after edge k. S1 holds TRAIN_WORD after edges k+1..k+train_len. training_active falls after edge k+train_len.
- A mode change takes effect on the first S1 capture after the input changes.
- Asynchronous reset mid-burst aborts training immediately and returns to RUN with all reset values.

## Test plan
- mode 1 from reset, bit_shift 0 -> first two D_OUT words 8'h02 then 8'h0C. The sequence repeats with period 127 bits, and word_counter equals the word count.
- mode 2, send 8'h11, 8'h22, 8'h33 with tx_valid, then drop tx_valid for 2 cycles with idle_word 8'hAA -> D_OUT is 11, 22, 33, AA, AA, and underflow_counter = 2.
- mode 0 with idle_word 8'hF0, bit_shift 0 -> 1 -> steady 8'hF0 becomes 8'h78 on the second word after the change; rotation glitch is only at the transition.
- train_start with train_len 5 in mode 3 -> exactly 5 words of 8'hB5 and training_active high for 5 cycles. Ramp resumes from its pre-train value, and word_counter does not count the training words.
- inject_error pulse in mode 0 with idle_word 8'h00 -> a single 8'h01 word. A pulse during TRAIN produces no corruption.
- Counters forced near all-ones -> saturate. reset_counters coincident with an increment -> 0. rstb asserted mid-training -> immediate reset values.
